// File: rtl/ppu_comp_pkg.sv
// Shared constants and types for the PPU layer compositor.
// Register addresses, pipeline latency and the colour type.
package ppu_comp_pkg;

   localparam logic [2:0] ADDR_EN   = 3'd0;
   localparam logic [2:0] ADDR_BG   = 3'd1;
   localparam logic [2:0] ADDR_KEY  = 3'd2;
   localparam logic [2:0] ADDR_FADE = 3'd3;
   localparam logic [2:0] ADDR_CMD  = 3'd4;

   localparam int unsigned PIPE_LAT    = 3;
   localparam int unsigned COLOR_W_DEF = 24;

   typedef logic [COLOR_W_DEF-1:0] rgb_t;

endpackage

// File: rtl/ppu_prio_select.sv
// Lowest-index-first priority encoder: reports whether any bit is set
// and the index of the lowest set bit.
module ppu_prio_select
   import ppu_comp_pkg::*;
#(
   parameter int unsigned WIDTH = 10
) (
   input  logic [WIDTH-1:0]                            i_vec,
   output logic                                        o_found,
   output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] o_idx
);

   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // Scan high to low so the lowest set bit is the last to be assigned.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_found = 1'b1;
            o_idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/ppu_compositor.sv
// Three-stage layer compositor with shadow registers committed once per frame.
// Define PPU_COMP_FADE_EN to add a per-channel fade in the final stage.
module ppu_compositor
   import ppu_comp_pkg::*;
#(
   parameter int unsigned        NUM_LAYERS = 20,
   parameter int unsigned        COLOR_W    = 24,
   parameter int unsigned        V_ACTIVE   = 480,
   parameter logic [COLOR_W-1:0] KEY_RESET  = 'h202020,
   parameter logic [COLOR_W-1:0] BG_RESET   = 'h202020
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          chipselect,
   input  logic                          write,
   input  logic [2:0]                    address,
   input  logic [31:0]                   writedata,
   input  logic [9:0]                    hcount,
   input  logic [9:0]                    vcount,
   input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
   output logic [COLOR_W-1:0]            RGB_output,
   output logic [9:0]                    hcount_out,
   output logic [9:0]                    vcount_out
);

   localparam int unsigned LO_N  = NUM_LAYERS / 2;
   localparam int unsigned HI_N  = NUM_LAYERS - LO_N;
   localparam int unsigned LO_IW = (LO_N > 1) ? $clog2(LO_N) : 1;
   localparam int unsigned HI_IW = (HI_N > 1) ? $clog2(HI_N) : 1;
   localparam int unsigned IDX_W = $clog2(NUM_LAYERS);

   // Register interface
   logic                  w_wr_en;
   logic                  w_force;
   logic                  w_commit;
   logic                  w_unused_wd;

   logic [NUM_LAYERS-1:0] r_sh_en;
   logic [COLOR_W-1:0]    r_sh_bg;
   logic [COLOR_W-1:0]    r_sh_key;
   logic [NUM_LAYERS-1:0] r_act_en;
   logic [COLOR_W-1:0]    r_act_bg;
   logic [COLOR_W-1:0]    r_act_key;

   // Pipeline
   logic [NUM_LAYERS-1:0]         w_opaque;
   logic [NUM_LAYERS*COLOR_W-1:0] r_s1_rgb;
   logic [NUM_LAYERS-1:0]         r_s1_opaque;
   logic [COLOR_W-1:0]            r_s1_bg;
   logic [9:0]                    r_s1_h;
   logic [9:0]                    r_s1_v;

   logic [COLOR_W-1:0]            w_s1_lay [NUM_LAYERS];
   logic                          w_lo_found;
   logic                          w_hi_found;
   logic [LO_IW-1:0]              w_lo_idx;
   logic [HI_IW-1:0]              w_hi_idx;
   logic [IDX_W-1:0]              w_sel;
   logic                          w_any;

   logic [COLOR_W-1:0]            r_s2_rgb;
   logic [9:0]                    r_s2_h;
   logic [9:0]                    r_s2_v;

   logic [COLOR_W-1:0]            w_s3_rgb;
   logic [COLOR_W-1:0]            r_s3_rgb;
   logic [9:0]                    r_s3_h;
   logic [9:0]                    r_s3_v;

   assign w_wr_en     = chipselect & write;
   assign w_force     = w_wr_en && (address == ADDR_CMD) && writedata[0];
   assign w_commit    = ((hcount == 10'd0) && (vcount == 10'(V_ACTIVE))) || w_force;
   assign w_unused_wd = ^writedata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sh_en  <= '1;
         r_sh_bg  <= BG_RESET;
         r_sh_key <= KEY_RESET;
      end else if (w_wr_en) begin
         case (address)
            ADDR_EN:  r_sh_en  <= writedata[NUM_LAYERS-1:0];
            ADDR_BG:  r_sh_bg  <= writedata[COLOR_W-1:0];
            ADDR_KEY: r_sh_key <= writedata[COLOR_W-1:0];
            default:  ;
         endcase
      end
   end

   // Active set samples the shadow before this edge's write lands.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_act_en  <= '1;
         r_act_bg  <= BG_RESET;
         r_act_key <= KEY_RESET;
      end else if (w_commit) begin
         r_act_en  <= r_sh_en;
         r_act_bg  <= r_sh_bg;
         r_act_key <= r_sh_key;
      end
   end

   // S1: opacity is decided against the active set in force at the sampling edge.
   always_comb begin
      w_opaque = '0;
      for (int i = 0; i < int'(NUM_LAYERS); i++) begin
         w_opaque[i] = r_act_en[i] && (layer_rgb[i*COLOR_W +: COLOR_W] != r_act_key);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_rgb    <= '0;
         r_s1_opaque <= '0;
         r_s1_bg     <= '0;
         r_s1_h      <= '0;
         r_s1_v      <= '0;
      end else begin
         r_s1_rgb    <= layer_rgb;
         r_s1_opaque <= w_opaque;
         r_s1_bg     <= r_act_bg;
         r_s1_h      <= hcount;
         r_s1_v      <= vcount;
      end
   end

   // S2: two half-width encoders; the low half always wins when it has a hit.
   for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_lay
      assign w_s1_lay[g] = r_s1_rgb[g*COLOR_W +: COLOR_W];
   end

   ppu_prio_select #(
      .WIDTH (LO_N)
   ) u_prio_lo (
      .i_vec   (r_s1_opaque[LO_N-1:0]),
      .o_found (w_lo_found),
      .o_idx   (w_lo_idx)
   );

   ppu_prio_select #(
      .WIDTH (HI_N)
   ) u_prio_hi (
      .i_vec   (r_s1_opaque[NUM_LAYERS-1:LO_N]),
      .o_found (w_hi_found),
      .o_idx   (w_hi_idx)
   );

   always_comb begin
      if (w_lo_found) begin
         w_sel = IDX_W'(w_lo_idx);
      end else begin
         w_sel = IDX_W'(LO_N) + IDX_W'(w_hi_idx);
      end
   end

   assign w_any = w_lo_found | w_hi_found;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s2_rgb <= '0;
         r_s2_h   <= '0;
         r_s2_v   <= '0;
      end else begin
         r_s2_rgb <= w_any ? w_s1_lay[w_sel] : r_s1_bg;
         r_s2_h   <= r_s1_h;
         r_s2_v   <= r_s1_v;
      end
   end

`ifdef PPU_COMP_FADE_EN
   logic [3:0] r_sh_fade;
   logic [3:0] r_act_fade;
   logic [3:0] r_s1_fade;
   logic [3:0] r_s2_fade;

   // Fade level travels with its pixel so a commit never splits a pixel's settings.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sh_fade  <= '0;
         r_act_fade <= '0;
         r_s1_fade  <= '0;
         r_s2_fade  <= '0;
      end else begin
         if (w_wr_en && (address == ADDR_FADE)) begin
            r_sh_fade <= writedata[3:0];
         end
         if (w_commit) begin
            r_act_fade <= r_sh_fade;
         end
         r_s1_fade <= r_act_fade;
         r_s2_fade <= r_s1_fade;
      end
   end

   if (COLOR_W == 24) begin : g_fade
      logic [4:0]  w_mul;
      logic [12:0] w_prod [3];

      always_comb begin
         w_mul    = 5'd16 - {1'b0, r_s2_fade};
         w_s3_rgb = '0;
         for (int c = 0; c < 3; c++) begin
            w_prod[c]            = {5'd0, r_s2_rgb[c*8 +: 8]} * {8'd0, w_mul};
            w_s3_rgb[c*8 +: 8] = 8'(w_prod[c] >> 4);
         end
      end
   end else begin : g_no_fade
      assign w_s3_rgb = r_s2_rgb;
   end
`else
   assign w_s3_rgb = r_s2_rgb;
`endif

   // S3: output register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s3_rgb <= '0;
         r_s3_h   <= '0;
         r_s3_v   <= '0;
      end else begin
         r_s3_rgb <= w_s3_rgb;
         r_s3_h   <= r_s2_h;
         r_s3_v   <= r_s2_v;
      end
   end

   assign RGB_output = r_s3_rgb;
   assign hcount_out = r_s3_h;
   assign vcount_out = r_s3_v;

endmodule
